// File: rtl/alu4_mul_ctrl.sv
// Shift-and-add 4x4 unsigned multiplier controller. It drives an external 4-bit adder
// and runs four ADD/SHIFT iterations per request.
// Optional feature: define ALU4_MUL_ZERO_SKIP_EN to finish at once when either operand is zero.
module alu4_mul_ctrl #(
  parameter logic [2:0] ALU_OP_ADD = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_co
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     r_state, w_state_nx;
  logic [1:0] r_cnt,   w_cnt_nx;
  logic [3:0] r_mcand, w_mcand_nx;
  logic       r_c,     w_c_nx;
  logic [3:0] r_ph,    w_ph_nx;
  logic [3:0] r_pl,    w_pl_nx;

  // NOTE: every register, including the datapath, is cleared by the async reset and
  // updated only with non-blocking assignments, so an aborted multiply leaves no residue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_mcand <= 4'd0;
      r_c     <= 1'b0;
      r_ph    <= 4'd0;
      r_pl    <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_mcand <= w_mcand_nx;
      r_c     <= w_c_nx;
      r_ph    <= w_ph_nx;
      r_pl    <= w_pl_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_mcand_nx = r_mcand;
    w_c_nx     = r_c;
    w_ph_nx    = r_ph;
    w_pl_nx    = r_pl;
    alu_a      = 4'd0;
    alu_b      = 4'd0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_mcand_nx = a;
          w_pl_nx    = b;
          w_ph_nx    = 4'd0;
          w_c_nx     = 1'b0;
          w_cnt_nx   = 2'd0;
          w_state_nx = ADD;
`ifdef ALU4_MUL_ZERO_SKIP_EN
          if ((a == 4'd0) || (b == 4'd0)) begin
            w_pl_nx    = 4'd0;
            w_state_nx = DONE;
          end
`else
`endif
        end
      end
      ADD: begin
        // Add the multiplicand only when the current multiplier bit is set.
        alu_a      = r_ph;
        alu_b      = r_pl[0] ? r_mcand : 4'd0;
        w_c_nx     = alu_co;
        w_ph_nx    = alu_result;
        w_state_nx = SHIFT;
      end
      SHIFT: begin
        {w_c_nx, w_ph_nx, w_pl_nx} = {1'b0, r_c, r_ph, r_pl[3:1]};
        if (r_cnt == 2'd3) begin
          w_state_nx = DONE;
        end else begin
          w_cnt_nx   = r_cnt + 2'd1;
          w_state_nx = ADD;
        end
      end
      DONE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign alu_op = ALU_OP_ADD;
  assign busy   = (r_state == ADD) || (r_state == SHIFT);
  assign done   = (r_state == DONE);
  assign result = {r_ph, r_pl};

endmodule

// File: tb/tb_alu4_mul_ctrl.sv
// Self-checking bench for alu4_mul_ctrl: an arithmetic adder model, a table of vectors,
// random products checked against a*b, and directed corner-case sequences.
module tb_alu4_mul_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       busy, done;
  logic [7:0] result;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_co;

  int checks = 0;
  int errors = 0;

  alu4_mul_ctrl #(.ALU_OP_ADD(3'b000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_co     (alu_co)
  );

  // The external adder, modelled as plain 5-bit addition.
  assign {alu_co, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] exp_res;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycles from the accepting edge to the cycle in which done is sampled high.
  function automatic int exp_lat(input logic [3:0] x, input logic [3:0] y);
`ifdef ALU4_MUL_ZERO_SKIP_EN
    if ((x == 4'd0) || (y == 4'd0)) return 1;
`endif
    return 9;
  endfunction

  function automatic int exp_busy(input logic [3:0] x, input logic [3:0] y);
    return (exp_lat(x, y) == 1) ? 0 : 8;
  endfunction

  task automatic collect(output logic [7:0] res, output int lat, output int busy_cnt,
                         output bit co_seen);
    res = 8'd0; lat = 0; busy_cnt = 0; co_seen = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (alu_co) co_seen = 1'b1;
      if (done) begin
        res = result;
        check("alu_a_idle_at_done", 32'(alu_a), 32'd0);
        check("alu_b_idle_at_done", 32'(alu_b), 32'd0);
        break;
      end
      if (lat >= 40) begin
        check("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic run_mul(input logic [3:0] ta, input logic [3:0] tb_v, output logic [7:0] res,
                         output int lat, output int busy_cnt, output bit co_seen);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    collect(res, lat, busy_cnt, co_seen);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_hold", 32'(result), 32'(res));
  endtask

  vec_t       vecs[8];
  logic [7:0] res;
  int         lat, bcnt, ndone, gap;
  bit         co;
  logic [3:0] ra, rb;

  initial begin
    vecs[0] = '{4'd3,  4'd5,  8'h0F};
    vecs[1] = '{4'd15, 4'd15, 8'hE1};
    vecs[2] = '{4'd0,  4'd7,  8'h00};
    vecs[3] = '{4'd2,  4'd7,  8'h0E};
    vecs[4] = '{4'd1,  4'd1,  8'h01};
    vecs[5] = '{4'd8,  4'd8,  8'h40};
    vecs[6] = '{4'd15, 4'd1,  8'h0F};
    vecs[7] = '{4'd7,  4'd0,  8'h00};

    // Reset state.
    #1;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_alu_a",  32'(alu_a),  32'd0);
    check("rst_alu_b",  32'(alu_b),  32'd0);
    check("alu_op",     32'(alu_op), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      run_mul(vecs[i].va, vecs[i].vb, res, lat, bcnt, co);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].va, vecs[i].vb)));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt),
            32'(exp_busy(vecs[i].va, vecs[i].vb)));
      if (i == 1) check("15x15_carry_seen", 32'(co), 32'd1);
    end

    // Random products against plain multiplication.
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      run_mul(ra, rb, res, lat, bcnt, co);
      check($sformatf("rand%0d_%0dx%0d", i, ra, rb), 32'(res), 32'(int'(ra) * int'(rb)));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat(ra, rb)));
    end

    // start with new operands while busy must be ignored.
    @(negedge clk);
    a = 4'd3; b = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) begin a = 4'd9; b = 4'd9; start = 1'b1; end
      if (i == 5) start = 1'b0;
      if (done) begin lat = i; break; end
    end
    check("ignore_start_latency", 32'(lat), 32'd9);
    check("ignore_start_result",  32'(result), 32'h0F);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("ignore_start_no_rerun", 32'(ndone), 32'd0);
    check("ignore_start_hold",     32'(result), 32'h0F);

    // Reset in the middle of a SHIFT cycle aborts the multiply.
    @(negedge clk);
    a = 4'd3; b = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_busy",   32'(busy),   32'd0);
    check("mid_reset_result", 32'(result), 32'd0);
    check("mid_reset_done",   32'(done),   32'd0);
    @(negedge clk);
    a = 4'd2; b = 4'd7; start = 1'b1; reset_n = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    collect(res, lat, bcnt, co);
    check("after_reset_result",  32'(res), 32'h0E);
    check("after_reset_latency", 32'(lat), 32'd9);
    @(negedge clk);

    // start held high: back-to-back requests every 10 cycles.
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_done", 32'(done), 32'd1);
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!done && gap < 40);
      check($sformatf("b2b_gap%0d", k),    32'(gap),    32'd10);
      check($sformatf("b2b_result%0d", k), 32'(result), 32'h01);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_stopped", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
